// File: rtl/onehot_reg_bank_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// onehot_reg_bank_if : write/read/status bundle for the one-hot register bank
// Rev 1.0
// ---------------------------------------------------------------------------
interface onehot_reg_bank_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 4
);
  logic                 wr_en;
  logic [7:0]           wr_sel;
  logic [WIDTH-1:0]     wr_data;
  logic                 clr_valid;
  logic [2:0]           rd_addr_a;
  logic [2:0]           rd_addr_b;
  logic [WIDTH-1:0]     rd_data_a;
  logic [WIDTH-1:0]     rd_data_b;
  logic                 rd_valid_a;
  logic                 rd_valid_b;
  logic                 sel_err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output wr_en, wr_sel, wr_data, clr_valid, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, sel_err, err_cnt
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, clr_valid, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, sel_err, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/onehot_reg_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// onehot_reg_bank : 8-entry register bank, one-hot write select with
//                   illegal-select detection and two combinational read ports
// Rev 1.0
// ---------------------------------------------------------------------------
module onehot_reg_bank #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 4,
  parameter int ZERO_REG  = 0
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  onehot_reg_bank_if.slave   bus
);
  localparam int                   c_ENTRIES = 8;
  localparam logic [ERR_CNT_W-1:0] c_CNT_MAX = '1;

  logic                 w_onehot;
  logic                 w_legal;
  logic                 w_illegal;
  logic [WIDTH-1:0]     w_data_view [c_ENTRIES];
  logic [c_ENTRIES-1:0] w_valid_view;
  logic                 r_sel_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // x & (x-1) clears the lowest set bit; zero result means at most one bit set
  assign w_onehot  = (bus.wr_sel != 8'h00) &&
                     ((bus.wr_sel & (bus.wr_sel - 8'd1)) == 8'h00);
  assign w_legal   = bus.wr_en &&  w_onehot;
  assign w_illegal = bus.wr_en && !w_onehot;

  genvar i;
  generate
    for (i = 0; i < c_ENTRIES; i++) begin : g_entry
      if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
        assign w_data_view[i]  = '0;
        assign w_valid_view[i] = 1'b1;
      end else begin : g_reg
        logic [WIDTH-1:0] r_data;
        logic             r_valid;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
          end else begin
            if (w_legal && bus.wr_sel[i]) begin
              r_data  <= bus.wr_data;
              r_valid <= 1'b1;
            end else if (bus.clr_valid) begin
              r_valid <= 1'b0;
            end
          end
        end

        assign w_data_view[i]  = r_data;
        assign w_valid_view[i] = r_valid;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_sel_err <= w_illegal;
      if (w_illegal && (r_err_cnt != c_CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  // Reads come straight from stored state: no bypass of the in-flight write
  assign bus.rd_data_a  = w_data_view[bus.rd_addr_a];
  assign bus.rd_data_b  = w_data_view[bus.rd_addr_b];
  assign bus.rd_valid_a = w_valid_view[bus.rd_addr_a];
  assign bus.rd_valid_b = w_valid_view[bus.rd_addr_b];
  assign bus.sel_err    = r_sel_err;
  assign bus.err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_onehot_reg_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_onehot_reg_bank : directed vectors for onehot_reg_bank (plain and $zero)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_onehot_reg_bank;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  onehot_reg_bank_if #(.WIDTH(8), .ERR_CNT_W(4)) bus0 ();
  onehot_reg_bank_if #(.WIDTH(8), .ERR_CNT_W(4)) bus1 ();

  onehot_reg_bank #(.WIDTH(8), .ERR_CNT_W(4), .ZERO_REG(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  onehot_reg_bank #(.WIDTH(8), .ERR_CNT_W(4), .ZERO_REG(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_sel;
    logic [7:0] wr_data;
    logic       clr;
    logic [2:0] addr;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_err;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic [7:0] sel, logic [7:0] d, logic clr,
                              logic [2:0] a, logic [7:0] ed, logic ev,
                              logic ee, logic [3:0] ec);
    vec_t v;
    v.wr_en = en;  v.wr_sel = sel; v.wr_data = d; v.clr = clr; v.addr = a;
    v.exp_data = ed; v.exp_valid = ev; v.exp_err = ee; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle0();
    bus0.wr_en = 1'b0; bus0.wr_sel = 8'h00; bus0.wr_data = 8'h00; bus0.clr_valid = 1'b0;
  endtask

  task automatic idle1();
    bus1.wr_en = 1'b0; bus1.wr_sel = 8'h00; bus1.wr_data = 8'h00; bus1.clr_valid = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    bus0.wr_en = v.wr_en; bus0.wr_sel = v.wr_sel; bus0.wr_data = v.wr_data;
    bus0.clr_valid = v.clr; bus0.rd_addr_a = v.addr; bus0.rd_addr_b = v.addr;
    @(posedge clk); #1;
    chk($sformatf("vec%0d rd_data_a", idx),  bus0.rd_data_a,  v.exp_data);
    chk($sformatf("vec%0d rd_data_b", idx),  bus0.rd_data_b,  v.exp_data);
    chk($sformatf("vec%0d rd_valid_a", idx), bus0.rd_valid_a, v.exp_valid);
    chk($sformatf("vec%0d sel_err", idx),    bus0.sel_err,    v.exp_err);
    chk($sformatf("vec%0d err_cnt", idx),    bus0.err_cnt,    v.exp_cnt);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // sweep each one-hot code, read back with wr_en=0 and junk select, then illegal pair
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, 8'(1 << i), 8'(8'hA0 + i), 1'b0, 3'(i),
                        8'(8'hA0 + i), 1'b1, 1'b0, 4'd0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b0, 8'hFF, 8'hEE, 1'b0, 3'(i),
                        8'(8'hA0 + i), 1'b1, 1'b0, 4'd0));
    vecs.push_back(mk(1'b1, 8'h00, 8'h11, 1'b0, 3'd0, 8'hA0, 1'b1, 1'b1, 4'd1));
    vecs.push_back(mk(1'b1, 8'h18, 8'h22, 1'b0, 3'd3, 8'hA3, 1'b1, 1'b1, 4'd2));
    vecs.push_back(mk(1'b0, 8'h18, 8'h33, 1'b0, 3'd4, 8'hA4, 1'b1, 1'b0, 4'd2));

    rst_n = 1'b0;
    idle0(); idle1();
    bus0.rd_addr_a = 3'd0; bus0.rd_addr_b = 3'd0;
    bus1.rd_addr_a = 3'd0; bus1.rd_addr_b = 3'd0;
    #12;
    chk("reset rd_data_a",  bus0.rd_data_a,  8'h00);
    chk("reset rd_valid_a", bus0.rd_valid_a, 1'b0);
    chk("reset sel_err",    bus0.sel_err,    1'b0);
    chk("reset err_cnt",    bus0.err_cnt,    4'd0);
    chk("zero reset valid", bus1.rd_valid_a, 1'b1);
    chk("zero reset data",  bus1.rd_data_a,  8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) apply_vec(vecs[k], k);

    // read timing: same-cycle read sees old value, both ports identical
    bus0.wr_en = 1'b1; bus0.wr_sel = 8'h08; bus0.wr_data = 8'h5C;
    bus0.rd_addr_a = 3'd3; bus0.rd_addr_b = 3'd3;
    #1;
    chk("pre-edge rd_data_a", bus0.rd_data_a, 8'hA3);
    chk("pre-edge rd_data_b", bus0.rd_data_b, 8'hA3);
    @(posedge clk); #1;
    idle0();
    chk("post-edge rd_data_a", bus0.rd_data_a, 8'h5C);
    chk("post-edge rd_data_b", bus0.rd_data_b, 8'h5C);

    // clr_valid with coincident legal write to entry 6
    bus0.clr_valid = 1'b1; bus0.wr_en = 1'b1; bus0.wr_sel = 8'h40; bus0.wr_data = 8'h66;
    @(posedge clk); #1;
    idle0();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_d;
      exp_d = (i == 6) ? 8'h66 : (i == 3) ? 8'h5C : 8'(8'hA0 + i);
      bus0.rd_addr_a = 3'(i);
      #1;
      chk($sformatf("clr valid[%0d]", i), bus0.rd_valid_a, (i == 6) ? 1'b1 : 1'b0);
      chk($sformatf("clr data[%0d]", i),  bus0.rd_data_a,  exp_d);
    end

    // 14 more illegal writes: count saturates at 15, sel_err held high
    bus0.wr_en = 1'b1; bus0.wr_sel = 8'hC0; bus0.wr_data = 8'h99; bus0.rd_addr_a = 3'd7;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat%0d sel_err", k), bus0.sel_err, 1'b1);
      chk($sformatf("sat%0d err_cnt", k), bus0.err_cnt, (k + 3 > 15) ? 15 : k + 3);
    end
    idle0();
    @(posedge clk); #1;
    chk("sat idle sel_err", bus0.sel_err,   1'b0);
    chk("sat idle err_cnt", bus0.err_cnt,   4'd15);
    chk("sat entry7 data",  bus0.rd_data_a, 8'hA7);

    // asynchronous reset between edges, then a write held under reset
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async rd_data_a",  bus0.rd_data_a,  8'h00);
    chk("async rd_valid_a", bus0.rd_valid_a, 1'b0);
    chk("async err_cnt",    bus0.err_cnt,    4'd0);
    chk("async sel_err",    bus0.sel_err,    1'b0);
    bus0.wr_en = 1'b1; bus0.wr_sel = 8'h02; bus0.wr_data = 8'h77; bus0.rd_addr_a = 3'd1;
    @(posedge clk); #2;
    rst_n = 1'b1;
    idle0();
    #1;
    chk("reset-write data",  bus0.rd_data_a,  8'h00);
    chk("reset-write valid", bus0.rd_valid_a, 1'b0);

    // ZERO_REG instance
    bus1.wr_en = 1'b1; bus1.wr_sel = 8'h01; bus1.wr_data = 8'hFF; bus1.rd_addr_a = 3'd0;
    @(posedge clk); #1;
    chk("zero write data",    bus1.rd_data_a,  8'h00);
    chk("zero write valid",   bus1.rd_valid_a, 1'b1);
    chk("zero write sel_err", bus1.sel_err,    1'b0);
    chk("zero write err_cnt", bus1.err_cnt,    4'd0);
    bus1.wr_sel = 8'h02; bus1.wr_data = 8'h12; bus1.rd_addr_a = 3'd1;
    @(posedge clk); #1;
    chk("zero e1 data",  bus1.rd_data_a,  8'h12);
    chk("zero e1 valid", bus1.rd_valid_a, 1'b1);
    bus1.wr_en = 1'b0; bus1.wr_sel = 8'hFF; bus1.wr_data = 8'h99;
    @(posedge clk); #1;
    chk("zero ignore sel_err", bus1.sel_err,   1'b0);
    chk("zero ignore err_cnt", bus1.err_cnt,   4'd0);
    chk("zero ignore data",    bus1.rd_data_a, 8'h12);
    idle1();
    bus1.clr_valid = 1'b1; bus1.rd_addr_b = 3'd0;
    @(posedge clk); #1;
    idle1();
    chk("zero clr e1 valid", bus1.rd_valid_a, 1'b0);
    chk("zero clr e1 data",  bus1.rd_data_a,  8'h12);
    chk("zero clr e0 valid", bus1.rd_valid_b, 1'b1);
    chk("zero clr e0 data",  bus1.rd_data_b,  8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
